// File: rtl/sync_counter_nbit_if.sv
// sync_counter_nbit_if
// Control and status bundle for sync_counter_nbit. The master side drives
// the count controls (enable, direction, load strobe and value); the slave
// side is the counter, which returns q, qbar, tc and wrap.
// When SYNC_COUNTER_SAT_EN is defined the bundle also carries the
// saturation control sat, listed directly after up_dn.
interface sync_counter_nbit_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up_dn;
`ifdef SYNC_COUNTER_SAT_EN
    logic             sat;
`endif
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             wrap;

    // Controller side: issues count/load commands, observes the count.
    modport master (
        output en,
        output up_dn,
`ifdef SYNC_COUNTER_SAT_EN
        output sat,
`endif
        output load,
        output d,
        input  q,
        input  qbar,
        input  tc,
        input  wrap
    );

    // Counter side.
    modport slave (
        input  en,
        input  up_dn,
`ifdef SYNC_COUNTER_SAT_EN
        input  sat,
`endif
        input  load,
        input  d,
        output q,
        output qbar,
        output tc,
        output wrap
    );
endinterface

// File: rtl/sync_counter_nbit.sv
// sync_counter_nbit
// Parametrised modulo-MODULUS up/down counter with enable, synchronous
// parallel load (clamped to MODULUS-1), a combinational terminal-count
// output for cascading, and a registered one-cycle wrap pulse.
// clrbar is an asynchronous active-low clear.
// Optional feature macro: SYNC_COUNTER_SAT_EN adds the sat control, which
// parks the count at the terminal value instead of wrapping.
// Interface handshake: there is no valid/ready exchange; every posedge with
// clrbar=1 samples the controls, and q/wrap are valid from that edge on.
module sync_counter_nbit #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic               clk,
    input  logic               clrbar,
    sync_counter_nbit_if.slave bus
);

    // Reject an impossible count range at elaboration time.
    if (WIDTH < 1 || MODULUS < 2 || (WIDTH < 31 && MODULUS > (1 << WIDTH))) begin : g_bad_params
        $fatal(1, "sync_counter_nbit: MODULUS must be in 2..2**WIDTH");
    end

    // Terminal value for up counting, and MODULUS widened by one bit so the
    // load clamp comparison also works when MODULUS == 2**WIDTH.
    localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             at_top;
    logic             at_bot;
    logic             sat_on;

    assign at_top = (q_reg == TERM);
    assign at_bot = (q_reg == '0);

`ifdef SYNC_COUNTER_SAT_EN
    assign sat_on = bus.sat;
`else
    assign sat_on = 1'b0;
`endif

    // Next count: load beats counting; a boundary step either wraps (and
    // flags it) or, when saturation is on, parks at the terminal value.
    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        if (bus.load) begin
            if ({1'b0, bus.d} >= MOD_EXT) begin
                q_next = TERM;
            end else begin
                q_next = bus.d;
            end
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (at_top) begin
                    if (!sat_on) begin
                        q_next    = '0;
                        wrap_next = 1'b1;
                    end
                end else begin
                    q_next = q_reg + WIDTH'(1);
                end
            end else begin
                if (at_bot) begin
                    if (!sat_on) begin
                        q_next    = TERM;
                        wrap_next = 1'b1;
                    end
                end else begin
                    q_next = q_reg - WIDTH'(1);
                end
            end
        end
    end

    // Count and wrap-pulse registers, cleared asynchronously by clrbar.
    always_ff @(posedge clk or negedge clrbar) begin
        if (!clrbar) begin
            q_reg    <= '0;
            wrap_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
        end
    end

    // qbar comes from q itself so the pair can never disagree; tc is
    // zero-latency so the next cascaded stage can use it as its enable.
    assign bus.q    = q_reg;
    assign bus.qbar = ~q_reg;
    assign bus.wrap = wrap_reg;
    assign bus.tc   = bus.en & (bus.up_dn ? at_top : at_bot);

endmodule

// File: tb/tb_sync_counter_nbit.sv
// tb_sync_counter_nbit
// Scoreboard bench for sync_counter_nbit at WIDTH=3, MODULUS=6. The driver
// applies one command per cycle on the falling edge and pushes the expected
// {wrap, q} after the next rising edge; a monitor pops and compares after
// every rising edge. Covers the SYNC_COUNTER_SAT_EN build when defined.
module tb_sync_counter_nbit;
    localparam int W = 3;
    localparam int M = 6;

    logic clk = 1'b0;
    logic clrbar = 1'b0;
    always #5 clk = ~clk;

    sync_counter_nbit_if #(.WIDTH(W)) bus ();

    sync_counter_nbit #(.WIDTH(W), .MODULUS(M)) dut (
        .clk    (clk),
        .clrbar (clrbar),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int m_q   = 0;              // reference model count
    logic [W:0] exp_q[$];       // expected {wrap, q} per sampled edge

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // One command for one clock edge; reference model uses plain modular
    // arithmetic on an integer count.
    task automatic cycle(input bit e, input bit u, input bit l, input int dv, input bit s);
        int  nq;
        bit  w;
        @(negedge clk);
        bus.en    = e;
        bus.up_dn = u;
        bus.load  = l;
        bus.d     = W'(dv);
`ifdef SYNC_COUNTER_SAT_EN
        bus.sat   = s;
`endif
        w  = 1'b0;
        nq = m_q;
        if (!clrbar) begin
            nq = 0;
        end else if (l) begin
            nq = (dv >= M) ? M - 1 : dv;
        end else if (e) begin
            nq = (m_q + (u ? 1 : -1) + M) % M;
            w  = u ? (m_q == M - 1) : (m_q == 0);
`ifdef SYNC_COUNTER_SAT_EN
            if (w && s) begin
                nq = m_q;
                w  = 1'b0;
            end
`endif
        end
        m_q = nq;
        exp_q.push_back({w, W'(nq)});
    endtask

    // Monitor: compare every edge that has a pending expectation.
    logic [W:0]   mon_e;
    logic [W-1:0] mon_q;
    logic [W-1:0] mon_qb;
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_q  = mon_e[W-1:0];
            mon_qb = ~mon_q;
            check("q",    int'(bus.q),    int'(mon_q));
            check("qbar", int'(bus.qbar), int'(mon_qb));
            check("wrap", int'(bus.wrap), int'(mon_e[W]));
            check("tc",   int'(bus.tc),
                  int'(bus.en & (bus.up_dn ? (int'(mon_q) == M - 1) : (int'(mon_q) == 0))));
        end
    end

    initial begin
        bus.en = 1'b0; bus.up_dn = 1'b1; bus.load = 1'b0; bus.d = '0;
`ifdef SYNC_COUNTER_SAT_EN
        bus.sat = 1'b0;
`endif
        // Reset state, including tc following its equation from q=0.
        #12;
        check("rst_q",    int'(bus.q), 0);
        check("rst_qbar", int'(bus.qbar), 7);
        check("rst_wrap", int'(bus.wrap), 0);
        check("rst_tc_idle", int'(bus.tc), 0);
        bus.en = 1'b1; bus.up_dn = 1'b0; #1;
        check("rst_tc_down", int'(bus.tc), 1);
        bus.en = 1'b0; bus.up_dn = 1'b1;
        @(negedge clk);
        clrbar = 1'b1;

        // Count up through the wrap.
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 0);

        // Count down through the wrap from 0.
        cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);

        // Load priority and clamping, then hold.
        cycle(0, 1, 1, 2, 0);
        cycle(1, 1, 1, 4, 0);
        cycle(1, 0, 1, 7, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);

        // Async clear between edges while counting.
        cycle(1, 1, 1, 2, 0);
        cycle(1, 1, 0, 0, 0);
        @(posedge clk);
        #3;
        clrbar = 1'b0;
        #1;
        check("clr_q",    int'(bus.q), 0);
        check("clr_qbar", int'(bus.qbar), 7);
        check("clr_wrap", int'(bus.wrap), 0);
        m_q = 0;
        cycle(1, 1, 1, 5, 0);
        cycle(1, 1, 1, 3, 0);
        cycle(0, 1, 0, 0, 0);
        clrbar = 1'b1;

        // Direction flip at the boundary.
        cycle(0, 1, 1, 5, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

`ifdef SYNC_COUNTER_SAT_EN
        // Saturation parks at the terminal value, then leaves downwards.
        cycle(0, 1, 1, 3, 1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 1) == 1);
        end

        cycle(0, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
